// File: rtl/result_writeback_ctrl_pkg.sv
// Shared definitions for the result write-back block.
// Holds the default geometry (address width, lanes, lane width, row width),
// the controller state encoding and a helper that extracts one lane from a row.
package result_writeback_ctrl_pkg;

    localparam int ADDRESSSIZE_DEF = 10;
    localparam int LANES_DEF       = 8;
    localparam int LANEW_DEF       = 20;
    localparam int WORDSIZE_DEF    = LANES_DEF * LANEW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ACC  = 2'd2,
        ST_FIN  = 2'd3
    } wb_state_t;

    // Lane idx of a row at the default geometry; lane 0 is the least significant slice.
    function automatic logic [LANEW_DEF-1:0] lane_of(input logic [WORDSIZE_DEF-1:0] row,
                                                     input int unsigned idx);
        return row[idx*LANEW_DEF +: LANEW_DEF];
    endfunction

endpackage

// File: rtl/result_writeback_ctrl_lane_sat_add.sv
// One signed saturating adder lane.
// Ports:
//   a_i, b_i : signed LANEW-bit operands
//   sum_o    : a_i + b_i clamped to the signed LANEW-bit range
//   sat_o    : 1 when the clamp was applied
module lane_sat_add
    import result_writeback_ctrl_pkg::*;
#(
    parameter int LANEW = LANEW_DEF
) (
    input  logic signed [LANEW-1:0] a_i,
    input  logic signed [LANEW-1:0] b_i,
    output logic signed [LANEW-1:0] sum_o,
    output logic                    sat_o
);

    localparam logic [LANEW-1:0] MAXV = {1'b0, {(LANEW-1){1'b1}}};
    localparam logic [LANEW-1:0] MINV = {1'b1, {(LANEW-1){1'b0}}};

    // Returns {sat, sum}. Overflow shows as the two top bits of the
    // sign-extended sum disagreeing; the extra top bit gives the true sign.
    function automatic logic [LANEW:0] sat_add(input logic signed [LANEW-1:0] a,
                                               input logic signed [LANEW-1:0] b);
        logic signed [LANEW:0] wide;
        wide = {a[LANEW-1], a} + {b[LANEW-1], b};
        if (wide[LANEW] != wide[LANEW-1]) begin
            return {1'b1, (wide[LANEW] ? MINV : MAXV)};
        end
        return {1'b0, wide[LANEW-1:0]};
    endfunction

    assign {sat_o, sum_o} = sat_add(a_i, b_i);

endmodule

// File: rtl/result_writeback_ctrl.sv
// Write-back controller between the multiplier accumulators and SRAM_Results.
// Rows arrive on a valid/ready stream and go to consecutive SRAM rows from a
// programmed base (wrapping at the top of the address space). In accumulate
// mode each row is read, added lane-wise with saturation, and written back,
// giving one row every two cycles.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : job start pulse, honoured only when idle
//   base_addr         : first destination row
//   row_count         : rows in the job (0 allowed)
//   acc_mode          : 1 = read-add-write, 0 = overwrite
//   in_valid/in_ready : row handshake, in_data is the row
//   sram_we/addr/wdata: buffer access (we=0 is a read)
//   sram_rdata        : buffer read data, one cycle after a read
//   busy, done        : job active, one-cycle completion pulse
//   sat_flag          : sticky lane-saturation flag for the current job
module result_writeback_ctrl
    import result_writeback_ctrl_pkg::*;
#(
    parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
    parameter int LANES       = LANES_DEF,
    parameter int LANEW       = LANEW_DEF,
    parameter int WORDSIZE    = LANES * LANEW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] row_count,
    input  logic                   acc_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDSIZE-1:0]    in_data,
    output logic                   sram_we,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    output logic [WORDSIZE-1:0]    sram_wdata,
    input  logic [WORDSIZE-1:0]    sram_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    wb_state_t              state_q, state_d;
    logic [ADDRESSSIZE-1:0] ptr_q, ptr_d;
    logic [ADDRESSSIZE-1:0] remaining_q, remaining_d;
    logic                   mode_q, mode_d;
    logic                   sat_q, sat_d;
    logic [WORDSIZE-1:0]    hold_q;
    logic [WORDSIZE-1:0]    acc_row;
    logic [LANES-1:0]       lane_sat;
    logic                   take_row;

    // in_ready depends only on state, so the handshake is formed from state directly.
    assign take_row = in_valid && (state_q == ST_RUN);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_sat_add #(.LANEW(LANEW)) u_lane (
            .a_i  (sram_rdata[g*LANEW +: LANEW]),
            .b_i  (hold_q[g*LANEW +: LANEW]),
            .sum_o(acc_row[g*LANEW +: LANEW]),
            .sat_o(lane_sat[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            sat_q       <= sat_d;
        end
    end

    // Row held for the add cycle; only meaningful in ACC, so no reset.
    always_ff @(posedge clk) begin
        if (take_row && mode_q) begin
            hold_q <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        sat_d       = sat_q;
        in_ready    = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        done        = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = row_count;
                    mode_d      = acc_mode;
                    sat_d       = 1'b0;
                    state_d     = (row_count == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready  = 1'b1;
                sram_addr = ptr_q;
                // With no row (or an accumulate row) the access is a read of ptr.
                if (take_row) begin
                    if (!mode_q) begin
                        sram_we     = 1'b1;
                        sram_wdata  = in_data;
                        ptr_d       = ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = (remaining_q == ADDRESSSIZE'(1)) ? ST_FIN : ST_RUN;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                sram_we     = 1'b1;
                sram_addr   = ptr_q;
                sram_wdata  = acc_row;
                ptr_d       = ptr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (|lane_sat) begin
                    sat_d = 1'b1;
                end
                state_d = (remaining_q == ADDRESSSIZE'(1)) ? ST_FIN : ST_RUN;
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sat_flag = sat_q;

endmodule

// File: tb/tb_result_writeback_ctrl.sv
module tb_result_writeback_ctrl;
    import result_writeback_ctrl_pkg::*;

    localparam int AW = 10;
    localparam int LN = 8;
    localparam int LW = 20;
    localparam int WS = LN * LW;
    localparam int DEPTH = 1 << AW;
    localparam int SMAX = (1 << (LW - 1)) - 1;
    localparam int SMIN = -(1 << (LW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] row_count;
    logic          acc_mode;
    logic          in_valid;
    logic          in_ready;
    logic [WS-1:0] in_data;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [WS-1:0] sram_wdata;
    logic [WS-1:0] sram_rdata;
    logic          busy;
    logic          done;
    logic          sat_flag;

    result_writeback_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .row_count (row_count),
        .acc_mode  (acc_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Buffer model: synchronous, read data valid the cycle after a we=0 access.
    logic [WS-1:0] mem [DEPTH];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [WS-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (sram_we) mem[sram_addr] <= sram_wdata;
        if (!sram_we) sram_rdata <= mem[sram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Access log, written only here.
    int   w_addr_q[$];
    int   w_cyc_q[$];
    bit   w_rdy_q[$];
    bit   w_rdok_q[$];
    int   done_q[$];
    logic          prev_we = 1'b1;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        chk("we_outside_job", WS'(sram_we & (~busy | done)), '0);
        if (sram_we) begin
            w_addr_q.push_back(int'(sram_addr));
            w_cyc_q.push_back(cyc);
            w_rdy_q.push_back(in_ready);
            w_rdok_q.push_back(!prev_we && (prev_addr == sram_addr));
        end
        if (done) done_q.push_back(cyc);
        prev_we   = sram_we;
        prev_addr = sram_addr;
    end

    // Reference model
    logic [WS-1:0] ref_mem [DEPTH];
    bit            ref_sat;
    logic [WS-1:0] stim_rows[$];

    function automatic logic [WS-1:0] ref_acc(input logic [WS-1:0] old_r, input logic [WS-1:0] add_r,
                                               output bit sat);
        logic [WS-1:0] r;
        int s;
        sat = 0;
        for (int i = 0; i < LN; i++) begin
            s = int'($signed(lane_of(old_r, i))) + int'($signed(lane_of(add_r, i)));
            if (s > SMAX) begin s = SMAX; sat = 1; end
            if (s < SMIN) begin s = SMIN; sat = 1; end
            r[i*LW +: LW] = LW'(s);
        end
        return r;
    endfunction

    function automatic logic [WS-1:0] row_all(input int v);
        logic [WS-1:0] r;
        for (int i = 0; i < LN; i++) r[i*LW +: LW] = LW'(v);
        return r;
    endfunction

    function automatic logic [WS-1:0] rand_row();
        logic [WS-1:0] r;
        for (int i = 0; i < WS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic preload(input int a, input logic [WS-1:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = AW'(a); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, WS'(in_ready), '0);
        chk({tag, "_sram_we"}, WS'(sram_we), '0);
        chk({tag, "_busy"}, WS'(busy), '0);
        chk({tag, "_done"}, WS'(done), '0);
        chk({tag, "_sat_flag"}, WS'(sat_flag), '0);
        chk({tag, "_sram_addr"}, WS'(sram_addr), '0);
        chk({tag, "_sram_wdata"}, sram_wdata, '0);
    endtask

    // One job: rows come from stim_rows. abort_at >= 0 asserts reset right
    // after that row's handshake (before its accumulate write).
    task automatic run_job(input int base, input int cnt, input bit acc, input bit bubbles,
                           input bit restart, input int abort_at);
        int  k = 0;
        int  guard = 0;
        int  w0, d0, start_cyc, n_apply, a;
        bit  hs, aborted = 0, s;
        w0 = w_addr_q.size();
        d0 = done_q.size();
        @(negedge clk);
        base_addr = AW'(base); row_count = AW'(cnt); acc_mode = acc; start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (k < cnt && guard < 400) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? stim_rows[k] : rand_row();
            if (restart && $urandom_range(0, 3) == 0) begin
                start = 1'b1; base_addr = AW'($urandom); row_count = AW'($urandom);
                acc_mode = 1'($urandom);
            end
            #1;
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hs) begin
                k++;
                if (k - 1 == abort_at) begin
                    rst = 1'b1;
                    #1;
                    reset_checks("abort");
                    aborted = 1;
                    @(negedge clk);
                    rst = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 400) chk("job_timeout", WS'(k), WS'(cnt));
        for (int w = 0; w < 8 && busy; w++) @(negedge clk);
        chk("busy_after_job", WS'(busy), '0);

        n_apply = aborted ? abort_at : cnt;
        for (int i = 0; i < n_apply; i++) begin
            a = (base + i) % DEPTH;
            if (acc) begin
                ref_mem[a] = ref_acc(ref_mem[a], stim_rows[i], s);
                ref_sat |= s;
            end else begin
                ref_mem[a] = stim_rows[i];
            end
        end

        chk("write_count", WS'(w_addr_q.size() - w0), WS'(n_apply));
        chk("done_count", WS'(done_q.size() - d0), WS'(aborted ? 0 : 1));
        for (int i = 0; i < n_apply && w0 + i < w_addr_q.size(); i++) begin
            chk("write_addr", WS'(w_addr_q[w0+i]), WS'((base + i) % DEPTH));
            if (acc) begin
                chk("acc_in_ready_low", WS'(w_rdy_q[w0+i]), '0);
                chk("acc_read_before_write", WS'(w_rdok_q[w0+i]), WS'(1));
            end else if (!bubbles && i > 0) begin
                chk("write_back_to_back", WS'(w_cyc_q[w0+i] - w_cyc_q[w0+i-1]), WS'(1));
            end
        end
        if (!aborted && done_q.size() > d0) begin
            // done is visible the cycle after the last write; with no rows,
            // the cycle after start is taken.
            if (cnt == 0) chk("done_timing_empty", WS'(done_q[d0] - start_cyc), WS'(1));
            else if (w_addr_q.size() > w0)
                chk("done_timing", WS'(done_q[d0] - w_cyc_q[w_addr_q.size()-1]), WS'(1));
        end
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % DEPTH;
            chk("mem_row", mem[a], ref_mem[a]);
        end
        if (!aborted) chk("sat_flag", WS'(sat_flag), WS'(ref_sat));
        ref_sat = 0;
    endtask

    logic [WS-1:0] r;
    int            cnt;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; acc_mode = 1'b0;
        in_valid = 1'b0; in_data = '0; ref_sat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            r = rand_row();
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = r;
            ref_mem[i] = r;
        end
        @(negedge clk);
        bd_we = 1'b0;

        // Overwrite, back-to-back rows
        stim_rows.delete();
        repeat (3) stim_rows.push_back(rand_row());
        run_job(5, 3, 0, 0, 0, -1);

        // Accumulate 100 + -30
        preload(9, row_all(100));
        stim_rows.delete();
        stim_rows.push_back(row_all(-30));
        run_job(9, 1, 1, 0, 0, -1);
        chk("acc_lanes_70", mem[9], row_all(70));

        // Positive and negative saturation on lane 0
        r = '0; r[LW-1:0] = 20'h7FFF0; preload(20, r);
        r = '0; r[LW-1:0] = 20'h80010; preload(21, r);
        stim_rows.delete();
        r = '0; r[LW-1:0] = 20'h00100; stim_rows.push_back(r);
        r = '0; r[LW-1:0] = 20'hFFF00; stim_rows.push_back(r);
        run_job(20, 2, 1, 0, 0, -1);
        r = mem[20]; chk("sat_pos_lane0", WS'(r[LW-1:0]), WS'(20'h7FFFF));
        r = mem[21]; chk("sat_neg_lane0", WS'(r[LW-1:0]), WS'(20'h80000));

        // Address wrap, then an empty job
        stim_rows.delete();
        repeat (3) stim_rows.push_back(rand_row());
        run_job(1022, 3, 0, 0, 0, -1);
        run_job(100, 0, 0, 0, 0, -1);

        // Random jobs with bubbles and start re-pulsed while busy
        for (int j = 0; j < 10; j++) begin
            stim_rows.delete();
            cnt = $urandom_range(0, 7);
            for (int i = 0; i < cnt; i++) stim_rows.push_back(rand_row());
            run_job((j % 3 == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1) : $urandom_range(0, DEPTH - 1),
                    cnt, 1'($urandom), 1, 1, -1);
        end

        // Reset between the read and the write of row 2 of 4, then a fresh job
        stim_rows.delete();
        repeat (4) stim_rows.push_back(rand_row());
        run_job(40, 4, 1, 0, 0, 2);
        stim_rows.delete();
        repeat (4) stim_rows.push_back(rand_row());
        run_job(40, 4, 0, 1, 0, -1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
